ahb_bus_arbiter: RTL and testbench
==================================

AHB_BUS_ARBITER -- requirements
Module: ahb_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_BEATS_MAX, default 16, which sets the maximum transfers one master may issue while the other is requesting.
REQ-002 SHALL have ports, in this order (name, direction, width, meaning):
- hclk, in, 1, sole clock, rising edge.
- hresetn, in, 1, reset; asynchronous, active-low.
- hbusreq, in, 2, bus request from each master (bit i = master i).
- m0_haddr, in, 32, master 0 address.
- m0_htrans, in, 2, master 0 transfer type.
- m0_hwrite, in, 1, master 0 direction.
- m0_hwdata, in, 32, master 0 write data.
- m1_haddr, m1_htrans, m1_hwrite, m1_hwdata: same as master 0, for master 1.
- hr_readyout, in, 1, bridge ready.
- hgrant, out, 2, one-hot address-phase grant.
- hmaster, out, 1, address-phase owner index.
- haddr, out, 32, muxed address to the bridge.
- htrans, out, 2, muxed transfer type to the bridge.
- hwrite, out, 1, muxed direction to the bridge.
- hwdata, out, 32, muxed write data to the bridge.
- hreadyin, out, 1, ready to the bridge.

Function
REQ-003 SHALL implement the FSM PARK, OWN0, OWN1; in PARK, hgrant=01 and htrans is forced to IDLE (00).
REQ-004 SHALL update the FSM, hgrant, hmaster and the beat counter only on a rising hclk edge with hr_readyout=1; all of them hold while hr_readyout=0.
REQ-005 SHALL treat the owner as releasable in a cycle when hbusreq[owner]=0, or its htrans=IDLE, or beat count >= NUM_BEATS_MAX with htrans=NONSEQ.
REQ-006 SHALL never hand over while the owner's htrans is SEQ (11) or BUSY (01), so a burst is not split.
REQ-007 SHALL re-arbitrate when releasable:
- both requesting: grant the master not last granted (round-robin).
- one requesting: grant that master.
- none requesting: go to PARK.
REQ-008 SHALL take PARK to OWNi one hready edge after hbusreq[i] rises; if both rise in the same cycle, master 0 wins from reset, round-robin thereafter.
REQ-009 SHALL drive haddr, htrans and hwrite combinationally from the master selected by hmaster.
REQ-010 SHALL keep a data-phase owner register hmaster_d, loaded from hmaster on each edge with hr_readyout=1; hwdata SHALL be muxed by hmaster_d, one cycle behind the address-phase owner.
REQ-011 SHALL drive hreadyin = hr_readyout, passed through combinationally.
REQ-012 SHALL count NONSEQ and SEQ transfers accepted (hr_readyout=1) for the current owner:
- 5-bit counter, saturating at NUM_BEATS_MAX.
- cleared on every grant change.
- the NONSEQ that causes a handover is not issued to the bridge: htrans is forced to IDLE in that cycle and the master re-requests.
REQ-013 SHALL keep the current grant and not enter PARK when hbusreq[owner] drops mid-burst with htrans=SEQ; release happens at the next IDLE or NONSEQ.

Reset
REQ-014 SHALL, while hresetn=0 (asynchronously):
- state = PARK.
- hgrant = 01, hmaster = 0, hmaster_d = 0.
- beat count = 0.
- last-granted = 1, so master 0 wins the first tie.
- htrans output = 00.
REQ-015 SHALL, when reset asserts mid-burst, drop the burst immediately with no completion; after deassertion the first grant edge SHALL occur on the first hclk edge with hr_readyout=1.

Structure
REQ-016 SHALL place the HTRANS encodings (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11) and the FSM state encodings in the shared package ahb_pkg, used by the master, bridge and arbiter.
REQ-017 SHALL be a single module plus one sub-module, ahb_master_mux (combinational address/data mux selected by hmaster and hmaster_d).

Verification
REQ-018 SHALL cover these directed scenarios:
- Single request: hbusreq=01 from PARK, m0 issues NONSEQ 0x8000_0000 write 0xA5A5_0000 -> hgrant=01 after 1 edge; haddr matches; hwdata=0xA5A5_0000 in the following cycle.
- Simultaneous requests after reset: hbusreq=11 -> master 0 granted first; after m0 goes IDLE, hgrant=10 within 1 edge.
- Burst protection: m0 INCR4 (NONSEQ + 3 SEQ), m1 requests at beat 2 -> hgrant stays 01 until m0 htrans=IDLE or NONSEQ; no SEQ ever reaches the bridge under the wrong owner.
- Wait states: hr_readyout held 0 for 3 cycles during a handover -> hgrant, hmaster and hmaster_d frozen; hwdata still from the previous owner until ready.
- Fairness cap: NUM_BEATS_MAX=4, m0 streams single NONSEQs, m1 requesting -> handover after the 4th accepted beat; htrans=IDLE driven in the handover cycle.
- Asynchronous reset mid-burst: hresetn=0 between clock edges -> hgrant=01, htrans=00 immediately; after release, normal arbitration resumes.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings used by the masters, the bridge and the bus arbiter.
package ahb_pkg;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        StPark = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } arb_state_e;

    localparam int unsigned BeatCntW = 5;

    // BUSY or SEQ: the owner is inside a burst and must keep the bus.
    function automatic logic trans_in_burst(logic [1:0] trans);
        return (trans == TransSeq) || (trans == TransBusy);
    endfunction

    // NONSEQ or SEQ: a real transfer that counts as a beat when accepted.
    function automatic logic trans_is_beat(logic [1:0] trans);
        return (trans == TransNonseq) || (trans == TransSeq);
    endfunction

endpackage

// File: rtl/ahb_master_mux.sv
// Address/control mux keyed by the address-phase owner, write-data mux keyed by the
// data-phase owner.
module ahb_master_mux (
    input  logic        hmaster_i,
    input  logic        hmaster_d_i,
    input  logic [31:0] m0_haddr_i,
    input  logic [1:0]  m0_htrans_i,
    input  logic        m0_hwrite_i,
    input  logic [31:0] m0_hwdata_i,
    input  logic [31:0] m1_haddr_i,
    input  logic [1:0]  m1_htrans_i,
    input  logic        m1_hwrite_i,
    input  logic [31:0] m1_hwdata_i,
    output logic [31:0] haddr_o,
    output logic [1:0]  htrans_o,
    output logic        hwrite_o,
    output logic [31:0] hwdata_o
);

    assign haddr_o  = hmaster_i   ? m1_haddr_i  : m0_haddr_i;
    assign htrans_o = hmaster_i   ? m1_htrans_i : m0_htrans_i;
    assign hwrite_o = hmaster_i   ? m1_hwrite_i : m0_hwrite_i;
    assign hwdata_o = hmaster_d_i ? m1_hwdata_i : m0_hwdata_i;

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB arbiter: round-robin with burst protection, a per-owner beat cap and
// a park state that presents IDLE to the bridge.
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int unsigned NUM_BEATS_MAX = 16
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [1:0]  hbusreq,
    input  logic [31:0] m0_haddr,
    input  logic [1:0]  m0_htrans,
    input  logic        m0_hwrite,
    input  logic [31:0] m0_hwdata,
    input  logic [31:0] m1_haddr,
    input  logic [1:0]  m1_htrans,
    input  logic        m1_hwrite,
    input  logic [31:0] m1_hwdata,
    input  logic        hr_readyout,
    output logic [1:0]  hgrant,
    output logic        hmaster,
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [31:0] hwdata,
    output logic        hreadyin
);

    localparam logic [BeatCntW-1:0] MaxBeats = BeatCntW'(NUM_BEATS_MAX);

    arb_state_e          state_q, state_d;
    logic [1:0]          hgrant_q;
    logic                hmaster_q;
    logic                hmaster_d_q;
    logic [BeatCntW-1:0] beat_cnt_q;
    logic                last_q;
    logic [1:0]          owner_trans;
    logic                releasable;
    logic                handover;

    ahb_master_mux u_mux (
        .hmaster_i   (hmaster_q),
        .hmaster_d_i (hmaster_d_q),
        .m0_haddr_i  (m0_haddr),
        .m0_htrans_i (m0_htrans),
        .m0_hwrite_i (m0_hwrite),
        .m0_hwdata_i (m0_hwdata),
        .m1_haddr_i  (m1_haddr),
        .m1_htrans_i (m1_htrans),
        .m1_hwrite_i (m1_hwrite),
        .m1_hwdata_i (m1_hwdata),
        .haddr_o     (haddr),
        .htrans_o    (owner_trans),
        .hwrite_o    (hwrite),
        .hwdata_o    (hwdata)
    );

    always_comb begin
        state_d    = state_q;
        releasable = 1'b1;
        if (state_q != StPark) begin
            releasable = !trans_in_burst(owner_trans) &&
                         (!hbusreq[hmaster_q] || (owner_trans == TransIdle) ||
                          ((beat_cnt_q >= MaxBeats) && (owner_trans == TransNonseq)));
        end
        if (releasable) begin
            unique case (hbusreq)
                2'b11:   state_d = last_q ? StOwn0 : StOwn1;
                2'b01:   state_d = StOwn0;
                2'b10:   state_d = StOwn1;
                default: state_d = StPark;
            endcase
        end
        handover = (state_d != state_q);
        // A NONSEQ that loses the bus is withheld; the master re-issues it later.
        htrans = ((state_q == StPark) || handover) ? TransIdle : owner_trans;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= StPark;
            hgrant_q    <= 2'b01;
            hmaster_q   <= 1'b0;
            hmaster_d_q <= 1'b0;
            beat_cnt_q  <= '0;
            last_q      <= 1'b1;
        end else if (hr_readyout) begin
            state_q     <= state_d;
            hgrant_q    <= (state_d == StOwn1) ? 2'b10 : 2'b01;
            hmaster_q   <= (state_d == StOwn1);
            hmaster_d_q <= hmaster_q;
            if (handover) begin
                beat_cnt_q <= '0;
                if (state_d != StPark) begin
                    last_q <= (state_d == StOwn1);
                end
            end else if (trans_is_beat(htrans) && (beat_cnt_q < MaxBeats)) begin
                beat_cnt_q <= beat_cnt_q + 5'd1;
            end
        end
    end

    assign hgrant   = hgrant_q;
    assign hmaster  = hmaster_q;
    assign hreadyin = hr_readyout;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model of the arbitration rules.
module tb_ahb_bus_arbiter;

    localparam int MaxBeats = 4;

    logic        hclk;
    logic        hresetn;
    logic [1:0]  hbusreq;
    logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
    logic [1:0]  m0_htrans, m1_htrans;
    logic        m0_hwrite, m1_hwrite;
    logic        hr_readyout;
    logic [1:0]  hgrant;
    logic        hmaster;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hreadyin;

    ahb_bus_arbiter #(.NUM_BEATS_MAX(MaxBeats)) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .hbusreq     (hbusreq),
        .m0_haddr    (m0_haddr),
        .m0_htrans   (m0_htrans),
        .m0_hwrite   (m0_hwrite),
        .m0_hwdata   (m0_hwdata),
        .m1_haddr    (m1_haddr),
        .m1_htrans   (m1_htrans),
        .m1_hwrite   (m1_hwrite),
        .m1_hwdata   (m1_hwdata),
        .hr_readyout (hr_readyout),
        .hgrant      (hgrant),
        .hmaster     (hmaster),
        .haddr       (haddr),
        .htrans      (htrans),
        .hwrite      (hwrite),
        .hwdata      (hwdata),
        .hreadyin    (hreadyin)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic [1:0]  grant;
        logic        master;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [31:0] wdata;
        logic        ready;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   fixed_data = 0;

    // Model: owner -1 means parked; last is the master most recently granted.
    int m_owner, m_last, m_beats, m_downer;

    function automatic void model_reset();
        m_owner  = -1;
        m_last   = 1;
        m_beats  = 0;
        m_downer = 0;
    endfunction

    function automatic int decide(input logic [1:0] req, input logic [1:0] t0,
                                  input logic [1:0] t1);
        int t;
        if (m_owner >= 0) begin
            t = (m_owner == 1) ? int'(t1) : int'(t0);
            if (t == 3 || t == 1) return m_owner;
            if (req[m_owner] && t != 0 && !(m_beats >= MaxBeats && t == 2)) return m_owner;
        end
        if (req == 2'b11) return (m_last == 0) ? 1 : 0;
        if (req == 2'b01) return 0;
        if (req == 2'b10) return 1;
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive inputs, push the expected outputs, then advance the model on
    // the following rising edge if the DUT is out of reset and the bridge is ready.
    task automatic step(input logic [1:0] req, input logic [1:0] t0, input logic [1:0] t1,
                        input logic rdy, input logic rstn);
        exp_t e;
        int   nxt;
        int   m;
        hbusreq     = req;
        m0_htrans   = t0;
        m1_htrans   = t1;
        hr_readyout = rdy;
        hresetn     = rstn;
        if (!fixed_data) begin
            m0_haddr  = $urandom;
            m1_haddr  = $urandom;
            m0_hwdata = $urandom;
            m1_hwdata = $urandom;
            m0_hwrite = 1'($urandom);
            m1_hwrite = 1'($urandom);
        end
        if (!rstn) model_reset();
        nxt      = decide(req, t0, t1);
        m        = (m_owner == 1) ? 1 : 0;
        e.grant  = (m_owner == 1) ? 2'b10 : 2'b01;
        e.master = 1'(m);
        e.addr   = m ? m1_haddr : m0_haddr;
        e.write  = m ? m1_hwrite : m0_hwrite;
        e.trans  = (m_owner < 0 || nxt != m_owner) ? 2'b00 : (m ? t1 : t0);
        e.wdata  = (m_downer == 1) ? m1_hwdata : m0_hwdata;
        e.ready  = rdy;
        exp_q.push_back(e);
        @(posedge hclk);
        if (hresetn && hr_readyout) begin
            m_downer = m;
            if (nxt != m_owner) begin
                m_owner = nxt;
                m_beats = 0;
                if (nxt >= 0) m_last = nxt;
            end else if (e.trans == 2'b10 || e.trans == 2'b11) begin
                m_beats = (m_beats < MaxBeats) ? m_beats + 1 : MaxBeats;
            end
        end
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge hclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("hgrant",   32'(hgrant),   32'(e.grant));
                check("hmaster",  32'(hmaster),  32'(e.master));
                check("htrans",   32'(htrans),   32'(e.trans));
                check("haddr",    haddr,         e.addr);
                check("hwrite",   32'(hwrite),   32'(e.write));
                check("hwdata",   hwdata,        e.wdata);
                check("hreadyin", 32'(hreadyin), 32'(e.ready));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not finish");
    end

    initial begin : driver
        hbusreq = 2'b00; m0_htrans = 2'b00; m1_htrans = 2'b00; hr_readyout = 1'b1;
        m0_haddr = '0; m1_haddr = '0; m0_hwdata = '0; m1_hwdata = '0;
        m0_hwrite = 1'b0; m1_hwrite = 1'b0;
        hresetn = 1'b0;
        model_reset();
        repeat (2) @(posedge hclk);
        #1;
        step(2'b00, 2'b00, 2'b00, 1, 0);

        // Single request with a fixed write.
        fixed_data = 1;
        m0_haddr = 32'h8000_0000; m0_hwdata = 32'hA5A5_0000; m0_hwrite = 1'b1;
        m1_haddr = 32'h1234_5678; m1_hwdata = 32'h0BAD_F00D; m1_hwrite = 1'b0;
        step(2'b01, 2'b10, 2'b00, 1, 1);
        step(2'b01, 2'b10, 2'b00, 1, 1);
        step(2'b01, 2'b00, 2'b00, 1, 1);
        step(2'b00, 2'b00, 2'b00, 1, 1);
        step(2'b00, 2'b00, 2'b00, 1, 1);
        fixed_data = 0;

        // Simultaneous requests from reset: master 0 first, then master 1.
        step(2'b00, 2'b00, 2'b00, 1, 0);
        step(2'b11, 2'b10, 2'b10, 1, 1);
        step(2'b11, 2'b10, 2'b10, 1, 1);
        step(2'b11, 2'b00, 2'b10, 1, 1);
        step(2'b11, 2'b00, 2'b10, 1, 1);
        step(2'b00, 2'b00, 2'b00, 1, 1);

        // INCR4 burst on master 0 with master 1 requesting mid-burst.
        step(2'b00, 2'b00, 2'b00, 1, 0);
        step(2'b01, 2'b10, 2'b00, 1, 1);
        step(2'b01, 2'b10, 2'b00, 1, 1);
        step(2'b11, 2'b11, 2'b10, 1, 1);
        step(2'b10, 2'b01, 2'b10, 1, 1);
        step(2'b11, 2'b11, 2'b10, 1, 1);
        step(2'b11, 2'b00, 2'b10, 1, 1);
        step(2'b10, 2'b00, 2'b11, 1, 1);

        // Handover stalled by three wait states.
        step(2'b00, 2'b00, 2'b00, 1, 0);
        step(2'b01, 2'b10, 2'b00, 1, 1);
        step(2'b11, 2'b10, 2'b10, 1, 1);
        step(2'b11, 2'b00, 2'b10, 0, 1);
        step(2'b11, 2'b00, 2'b10, 0, 1);
        step(2'b11, 2'b00, 2'b10, 0, 1);
        step(2'b11, 2'b00, 2'b10, 1, 1);
        step(2'b11, 2'b00, 2'b10, 1, 1);

        // Beat cap: master 0 streams single NONSEQs while master 1 waits.
        step(2'b00, 2'b00, 2'b00, 1, 0);
        for (int i = 0; i < 8; i++) step(2'b11, 2'b10, 2'b10, 1, 1);

        // Reset asserted mid-burst between edges, then normal arbitration again.
        step(2'b01, 2'b11, 2'b00, 1, 1);
        step(2'b11, 2'b11, 2'b10, 1, 0);
        step(2'b11, 2'b10, 2'b10, 0, 1);
        step(2'b11, 2'b10, 2'b10, 1, 1);
        step(2'b11, 2'b10, 2'b10, 1, 1);

        // Random traffic with wait states and occasional resets.
        for (int i = 0; i < 600; i++) begin
            step(2'($urandom), 2'($urandom), 2'($urandom),
                 1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 99) != 0));
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge hclk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
